sap1_clock_ctrl: RTL and testbench

- Converts debounced front-panel button levels (step, run/manual toggle, clear) into the SAP-1 CPU clock-enable and clear pulses.
- Sits directly downstream of the per-button debouncers and upstream of every CPU register's clock enable.
- Provides manual single-step and free-running auto modes with selectable rate.
- Honours the CPU HLT control signal.

---
 rtl/sap1_clk_pkg.sv | 15 +
 rtl/rise_detect.sv | 19 +
 rtl/sap1_clock_ctrl.sv | 98 +++++++++
 tb/tb_sap1_clock_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sap1_clk_pkg.sv
// Shared definitions for the SAP-1 front-panel clock controller.
// Holds the controller state encoding and the auto-rate divider defaults.
package sap1_clk_pkg;

   typedef enum logic [1:0] {
      MANUAL = 2'd0,
      AUTO   = 2'd1,
      HALTED = 2'd2
   } clk_state_t;

   // Each rate step divides the auto-mode period by four.
   localparam int unsigned RATE_SHIFT_STEP = 2;
   localparam logic [23:0] DEFAULT_DIV_MAX = 24'd12_499_999;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for an already-synchronised level.
// History resets high so a level held through reset gives no pulse.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= 1'b1;
      else        prev <= in;
   end

   assign rise = in & ~prev;

endmodule

// File: rtl/sap1_clock_ctrl.sv
// SAP-1 clock controller: turns debounced panel buttons into registered
// CPU clock-enable and clear pulses, with manual, auto and halted states.
module sap1_clock_ctrl
   import sap1_clk_pkg::*;
#(
   parameter int unsigned           DIV_WIDTH = 24,
   parameter logic [DIV_WIDTH-1:0]  DIV_MAX   = DIV_WIDTH'(DEFAULT_DIV_MAX)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       step_db,
   input  logic       mode_db,
   input  logic       clr_db,
   input  logic       hlt,
   input  logic [1:0] rate,
   output logic       cpu_ce,
   output logic       cpu_clr,
   output logic       mode_auto,
   output logic       halted
);

   clk_state_t           state;
   logic [DIV_WIDTH-1:0] div;
   logic [DIV_WIDTH-1:0] limit;
   logic [2:0]           shamt;
   logic                 step_rise;
   logic                 mode_rise;
   logic                 clr_rise;

   rise_detect u_step (.clk(clk), .rst_n(rst_n), .in(step_db), .rise(step_rise));
   rise_detect u_mode (.clk(clk), .rst_n(rst_n), .in(mode_db), .rise(mode_rise));
   rise_detect u_clr  (.clk(clk), .rst_n(rst_n), .in(clr_db),  .rise(clr_rise));

   assign shamt = 3'(RATE_SHIFT_STEP * 32'(rate));
   assign limit = DIV_MAX >> shamt;

   // Priority: clear, then halt, then mode toggle, then step / divider tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= MANUAL;
         div       <= '0;
         cpu_ce    <= 1'b0;
         cpu_clr   <= 1'b0;
         mode_auto <= 1'b0;
         halted    <= 1'b0;
      end else begin
         cpu_ce  <= 1'b0;
         cpu_clr <= 1'b0;
         if (clr_rise) begin
            state     <= MANUAL;
            div       <= '0;
            cpu_clr   <= 1'b1;
            mode_auto <= 1'b0;
            halted    <= 1'b0;
         end else begin
            case (state)
               MANUAL: begin
                  if (hlt) begin
                     state  <= HALTED;
                     halted <= 1'b1;
                  end else if (mode_rise) begin
                     state     <= AUTO;
                     div       <= '0;
                     mode_auto <= 1'b1;
                  end else if (step_rise) begin
                     cpu_ce <= 1'b1;
                  end
               end
               AUTO: begin
                  if (hlt) begin
                     state     <= HALTED;
                     halted    <= 1'b1;
                     mode_auto <= 1'b0;
                  end else if (mode_rise) begin
                     state     <= MANUAL;
                     div       <= '0;
                     mode_auto <= 1'b0;
                  end else if (div >= limit) begin
                     // >= so a shrinking limit fires at once instead of wrapping
                     cpu_ce <= 1'b1;
                     div    <= '0;
                  end else begin
                     div <= div + 1'b1;
                  end
               end
               HALTED: ;
               default: begin
                  state     <= MANUAL;
                  div       <= '0;
                  mode_auto <= 1'b0;
                  halted    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sap1_clock_ctrl.sv
// Directed bench for sap1_clock_ctrl with DIV_MAX=15, checked every cycle
// against a cycle-count model plus literal expectations at key points.
module tb_sap1_clock_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       step_db, mode_db, clr_db, hlt;
   logic [1:0] rate;
   logic       cpu_ce, cpu_clr, mode_auto, halted;

   int errors = 0;
   int checks = 0;
   int ce_count = 0;

   sap1_clock_ctrl #(.DIV_WIDTH(24), .DIV_MAX(24'd15)) dut (
      .clk(clk), .rst_n(rst_n), .step_db(step_db), .mode_db(mode_db),
      .clr_db(clr_db), .hlt(hlt), .rate(rate), .cpu_ce(cpu_ce),
      .cpu_clr(cpu_clr), .mode_auto(mode_auto), .halted(halted)
   );

   always #5 clk = ~clk;

   // Model: mode flags plus number of cycles elapsed since the last tick/entry.
   bit m_auto, m_halted, m_ce, m_clr;
   bit p_step, p_mode, p_clr;
   int elapsed;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_auto = 0; m_halted = 0; m_ce = 0; m_clr = 0; elapsed = 0;
         p_step = 1; p_mode = 1; p_clr = 1;
      end else begin
         bit sr, mr, cr;
         int period_limit;
         sr = step_db && !p_step;
         mr = mode_db && !p_mode;
         cr = clr_db && !p_clr;
         p_step = step_db; p_mode = mode_db; p_clr = clr_db;
         period_limit = 15 / (1 << (2 * int'(rate)));
         m_ce = 0; m_clr = 0;
         if (cr) begin
            m_clr = 1; m_auto = 0; m_halted = 0; elapsed = 0;
         end else if (!m_halted) begin
            if (hlt) begin
               m_halted = 1; m_auto = 0;
            end else if (mr) begin
               m_auto = !m_auto; elapsed = 0;
            end else if (m_auto) begin
               if (elapsed >= period_limit) begin m_ce = 1; elapsed = 0; end
               else elapsed = elapsed + 1;
            end else if (sr) begin
               m_ce = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cpu_ce === 1'b1) ce_count++;
      checks++;
      if ({cpu_ce, cpu_clr, mode_auto, halted} !== {m_ce, m_clr, m_auto, m_halted}) begin
         errors++;
         $display("FAIL model_cmp t=%0t: got ce/clr/auto/halt=%b%b%b%b required %b%b%b%b",
                  $time, cpu_ce, cpu_clr, mode_auto, halted, m_ce, m_clr, m_auto, m_halted);
      end
      checks++;
      if (cpu_ce && cpu_clr) begin
         errors++;
         $display("FAIL ce_clr_excl t=%0t: got both high required not both", $time);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   int c0;

   initial begin
      rst_n = 0; step_db = 1; mode_db = 0; clr_db = 0; hlt = 0; rate = 2'd0;
      #1;
      chk("reset_ce", int'(cpu_ce), 0);
      chk("reset_auto", int'(mode_auto), 0);
      tick(3);
      rst_n = 1;
      tick(3);
      chk("held_step_no_pulse", ce_count, 0);

      // 1: manual single step
      step_db = 0; tick(2);
      c0 = ce_count;
      step_db = 1; tick(1);
      chk("step_latency", int'(cpu_ce), 1);
      tick(4);
      chk("step_one_pulse", ce_count - c0, 1);
      chk("step_manual", int'(mode_auto), 0);

      // 2: auto mode, rate 0
      step_db = 0; mode_db = 1; tick(1);
      chk("enter_auto", int'(mode_auto), 1);
      tick(15);
      chk("auto_no_early", int'(cpu_ce), 0);
      tick(1);
      chk("auto_first_16", int'(cpu_ce), 1);
      c0 = ce_count;
      for (int i = 0; i < 32; i++) begin
         step_db = i[0];
         tick(1);
      end
      chk("auto_period_16", ce_count - c0, 2);

      // 3: rate change mid-count
      step_db = 0; tick(10);
      rate = 2'd1; tick(1);
      chk("rate_shrink_fire", int'(cpu_ce), 1);
      c0 = ce_count; tick(8);
      chk("rate1_period_4", ce_count - c0, 2);
      rate = 2'd3; c0 = ce_count; tick(5);
      chk("rate3_every", ce_count - c0, 5);
      rate = 2'd0;

      // 4: halt coinciding with terminal count
      tick(15);
      c0 = ce_count;
      hlt = 1; tick(1);
      chk("hlt_blocks_ce", int'(cpu_ce), 0);
      chk("hlt_halted", int'(halted), 1);
      hlt = 0;
      mode_db = 0; tick(1); step_db = 1; mode_db = 1; tick(2); step_db = 0; tick(2);
      chk("halted_stays", int'(halted), 1);
      chk("halted_no_ce", ce_count - c0, 0);

      // 5: clear out of halt
      clr_db = 1; tick(1);
      chk("clr_pulse", int'(cpu_clr), 1);
      chk("clr_unhalt", int'(halted), 0);
      chk("clr_manual", int'(mode_auto), 0);
      tick(1);
      chk("clr_one_cycle", int'(cpu_clr), 0);
      c0 = ce_count; step_db = 1; tick(2);
      chk("step_after_clr", ce_count - c0, 1);

      // 6: simultaneous clr/mode/step rises, then async reset mid-auto
      step_db = 0; mode_db = 0; clr_db = 0; tick(1);
      step_db = 1; mode_db = 1; clr_db = 1; tick(1);
      chk("combo_clr", int'(cpu_clr), 1);
      chk("combo_ce", int'(cpu_ce), 0);
      chk("combo_manual", int'(mode_auto), 0);
      mode_db = 0; clr_db = 0; step_db = 0; tick(1);
      mode_db = 1; tick(1);
      chk("auto_again", int'(mode_auto), 1);
      tick(5);
      #1 rst_n = 0;
      #1;
      chk("async_rst_auto", int'(mode_auto), 0);
      chk("async_rst_outs", int'({cpu_ce, cpu_clr, halted}), 0);
      tick(2);
      rst_n = 1;
      tick(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
